// File: rtl/multiport_register_file_pkg.sv
// rtl/multiport_register_file_pkg.sv - shared types and constants for the multi-port register file
package multiport_register_file_pkg;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_W-1:0] p_reg;
  typedef logic [RF_DATA_W-1:0] word;

  localparam word REG_ZERO = '0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;
endpackage

// File: rtl/multiport_register_file_if.sv
// rtl/multiport_register_file_if.sv - read/write port bundle of the register file
interface multiport_register_file_if
  import multiport_register_file_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_RD-1:0][ADDR_W-1:0] i_r_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] o_r_data;
  logic [NUM_WR-1:0]             i_w_en;
  logic [NUM_WR-1:0][ADDR_W-1:0] i_w_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] i_w_data;
  logic                          o_ready;
  logic                          o_wr_conflict;

  modport master (
    output i_r_addr, i_w_en, i_w_addr, i_w_data,
    input  o_r_data, o_ready, o_wr_conflict
  );

  modport slave (
    input  i_r_addr, i_w_en, i_w_addr, i_w_data,
    output o_r_data, o_ready, o_wr_conflict
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - resolves write-port priority (highest index wins) and flags collisions
module rf_write_arbiter
  import multiport_register_file_pkg::*;
#(
  parameter int NUM_WR = 2,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic [NUM_WR-1:0]             i_w_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] i_w_addr,
  output logic [NUM_WR-1:0]             o_w_en_eff,
  output logic                          o_collision
);
  // A port survives only if no higher-index enabled port targets the same non-zero address.
  always_comb begin
    o_w_en_eff  = '0;
    o_collision = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      o_w_en_eff[p] = i_w_en[p] && (i_w_addr[p] != '0);
      for (int q = p + 1; q < NUM_WR; q++) begin
        if (i_w_en[p] && i_w_en[q] && (i_w_addr[p] != '0) && (i_w_addr[p] == i_w_addr[q])) begin
          o_w_en_eff[p] = 1'b0;
          o_collision   = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - multi-port register file with clear sweep; REGFILE_BYPASS_EN adds write-to-read bypass
module multiport_register_file
  import multiport_register_file_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2
) (
  input logic                      i_clk,
  input logic                      i_rst,
  multiport_register_file_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_wr_conflict;
  logic [DATA_W-1:0] r_mem [NUM_REGS];

  logic              w_ready;
  logic              w_clr_en;
  logic [NUM_WR-1:0] w_w_en_gated;
  logic [NUM_WR-1:0] w_w_en_eff;
  logic              w_collision;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= RF_CLEAR;
      r_cnt         <= ADDR_W'(1);
      r_wr_conflict <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_conflict <= w_collision;
      if (w_clr_en) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == RF_CLEAR) && (r_cnt == LAST_REG)) begin
      w_state_nxt = RF_READY;
    end
  end

  always_comb begin
    w_ready  = (r_state == RF_READY);
    w_clr_en = (r_state == RF_CLEAR);
  end

  // Writes and collisions only exist once the sweep has finished.
  assign w_w_en_gated = w_ready ? bus.i_w_en : '0;

  rf_write_arbiter #(
    .NUM_WR (NUM_WR),
    .ADDR_W (ADDR_W)
  ) u_arb (
    .i_w_en      (w_w_en_gated),
    .i_w_addr    (bus.i_w_addr),
    .o_w_en_eff  (w_w_en_eff),
    .o_collision (w_collision)
  );

  always_ff @(posedge i_clk) begin
    if (w_clr_en) begin
      r_mem[r_cnt] <= '0;
    end
    for (int p = 0; p < NUM_WR; p++) begin
      if (w_w_en_eff[p]) begin
        r_mem[bus.i_w_addr[p]] <= bus.i_w_data[p];
      end
    end
  end

  always_comb begin
    bus.o_r_data = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      bus.o_r_data[r] = DATA_W'(REG_ZERO);
      if (w_ready && (bus.i_r_addr[r] != '0)) begin
        bus.o_r_data[r] = r_mem[bus.i_r_addr[r]];
`ifdef REGFILE_BYPASS_EN
        // At most one effective enable per address, so the arbiter's priority carries over.
        for (int p = 0; p < NUM_WR; p++) begin
          if (w_w_en_eff[p] && (bus.i_w_addr[p] == bus.i_r_addr[r])) begin
            bus.o_r_data[r] = bus.i_w_data[p];
          end
        end
`endif
      end
    end
  end

  assign bus.o_ready       = w_ready;
  assign bus.o_wr_conflict = r_wr_conflict;
endmodule
